// File: rtl/writeback_arbiter.sv
// Completion-side arbiter: per-unit result FIFOs, one registered retire per cycle.
// Define WB_RR_EN for round-robin grant; otherwise fixed priority Mem > Mult > AluMisc.
module writeback_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        am_wb_valid,
  output logic        am_wb_ready,
  input  logic [4:0]  am_wb_regdest,
  input  logic        am_wb_writereg,
  input  logic [31:0] am_wb_data,
  input  logic        mem_wb_valid,
  output logic        mem_wb_ready,
  input  logic [4:0]  mem_wb_regdest,
  input  logic        mem_wb_writereg,
  input  logic [31:0] mem_wb_data,
  input  logic        mul_wb_valid,
  output logic        mul_wb_ready,
  input  logic [4:0]  mul_wb_regdest,
  input  logic        mul_wb_writereg,
  input  logic [31:0] mul_wb_data,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_reg_data,
  output logic        wb_reg_we,
  output logic [4:0]  wb_sb_addr,
  output logic [1:0]  wb_sb_unit,
  output logic        wb_sb_enable,
  output logic        wb_retire
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 38;

  logic [2:0]         valid_s;
  logic [2:0]         full_s;
  logic [2:0]         empty_s;
  logic [2:0]         pop_s;
  logic [2:0][EW-1:0] in_entry_s;
  logic [2:0][EW-1:0] head_s;
  logic               grant_any_s;
  logic [1:0]         grant_unit_s;
  logic [EW-1:0]      grant_entry_s;
  logic [4:0]         addr_r;
  logic [31:0]        data_r;
  logic               we_r;
  logic [1:0]         unit_r;
  logic               retire_r;

  // Index k of every per-unit vector is the unit code k.
  assign valid_s       = {mul_wb_valid, mem_wb_valid, am_wb_valid};
  assign in_entry_s[0] = {am_wb_writereg, am_wb_regdest, am_wb_data};
  assign in_entry_s[1] = {mem_wb_writereg, mem_wb_regdest, mem_wb_data};
  assign in_entry_s[2] = {mul_wb_writereg, mul_wb_regdest, mul_wb_data};
  assign am_wb_ready   = ~full_s[0];
  assign mem_wb_ready  = ~full_s[1];
  assign mul_wb_ready  = ~full_s[2];

  for (genvar u = 0; u < 3; u++) begin : g_fifo
    logic [EW-1:0] store_r [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;

    // A full FIFO refuses a push even when it pops on the same edge.
    assign full_s[u]  = (count_r == CW'(FIFO_DEPTH));
    assign empty_s[u] = (count_r == {CW{1'b0}});
    assign push_s     = valid_s[u] & ~full_s[u];
    assign head_s[u]  = store_r[rd_ptr_r];

    // Pointer and occupancy tracking.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
        count_r  <= {CW{1'b0}};
      end else begin
        if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
        if (pop_s[u]) rd_ptr_r <= rd_ptr_r + PW'(1);
        case ({push_s, pop_s[u]})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end

    // Entry storage.
    always_ff @(posedge clock) begin
      if (push_s) store_r[wr_ptr_r] <= in_entry_s[u];
    end
  end

`ifdef WB_RR_EN
  logic [1:0] last_grant_r;
  logic [1:0] rr_cand_s;

  function automatic logic [1:0] next_unit(input logic [1:0] u);
    case (u)
      2'b00:   next_unit = 2'b01;
      2'b01:   next_unit = 2'b10;
      default: next_unit = 2'b00;
    endcase
  endfunction

  // Round-robin search starting after the last granted unit.
  always_comb begin
    grant_any_s  = 1'b0;
    grant_unit_s = 2'b00;
    rr_cand_s    = next_unit(last_grant_r);
    for (int k = 0; k < 3; k++) begin
      if (!grant_any_s && !empty_s[rr_cand_s]) begin
        grant_any_s  = 1'b1;
        grant_unit_s = rr_cand_s;
      end else begin
        grant_any_s  = grant_any_s;
      end
      rr_cand_s = next_unit(rr_cand_s);
    end
  end

  // Round-robin pointer; reset value gives AluMisc first priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_r <= 2'b10;
    end else if (grant_any_s) begin
      last_grant_r <= grant_unit_s;
    end
  end
`else
  // Fixed priority Mem > Mult > AluMisc.
  always_comb begin
    if (!empty_s[1]) begin
      grant_any_s  = 1'b1;
      grant_unit_s = 2'b01;
    end else if (!empty_s[2]) begin
      grant_any_s  = 1'b1;
      grant_unit_s = 2'b10;
    end else if (!empty_s[0]) begin
      grant_any_s  = 1'b1;
      grant_unit_s = 2'b00;
    end else begin
      grant_any_s  = 1'b0;
      grant_unit_s = 2'b00;
    end
  end
`endif

  // Select the granted head entry and its pop strobe.
  always_comb begin
    grant_entry_s = {EW{1'b0}};
    pop_s         = 3'b000;
    case (grant_unit_s)
      2'b00:   begin grant_entry_s = head_s[0]; pop_s = {2'b00, grant_any_s}; end
      2'b01:   begin grant_entry_s = head_s[1]; pop_s = {1'b0, grant_any_s, 1'b0}; end
      2'b10:   begin grant_entry_s = head_s[2]; pop_s = {grant_any_s, 2'b00}; end
      default: begin grant_entry_s = {EW{1'b0}}; pop_s = 3'b000; end
    endcase
  end

  // Retire registers; all load zero on a cycle without a grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_r   <= 5'd0;
      data_r   <= 32'd0;
      we_r     <= 1'b0;
      unit_r   <= 2'b00;
      retire_r <= 1'b0;
    end else if (grant_any_s) begin
      addr_r   <= grant_entry_s[36:32];
      data_r   <= grant_entry_s[31:0];
      we_r     <= grant_entry_s[37] & (grant_entry_s[36:32] != 5'd0);
      unit_r   <= grant_unit_s;
      retire_r <= 1'b1;
    end else begin
      addr_r   <= 5'd0;
      data_r   <= 32'd0;
      we_r     <= 1'b0;
      unit_r   <= 2'b00;
      retire_r <= 1'b0;
    end
  end

  assign wb_reg_addr  = addr_r;
  assign wb_sb_addr   = addr_r;
  assign wb_reg_data  = data_r;
  assign wb_reg_we    = we_r;
  assign wb_sb_enable = we_r;
  assign wb_sb_unit   = unit_r;
  assign wb_retire    = retire_r;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter against a queue-based reference model.
module tb_writeback_arbiter;
  localparam int DEPTH = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [2:0]        v  = 3'b000;
  logic [2:0]        wr = 3'b000;
  logic [2:0][4:0]   rd = '0;
  logic [2:0][31:0]  dt = '0;
  logic              am_rdy, mem_rdy, mul_rdy;
  logic [4:0]        reg_addr, sb_addr;
  logic [31:0]       reg_data;
  logic              reg_we, sb_en, retire;
  logic [1:0]        sb_unit;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference state: one queue of {writereg, regdest, data} per unit.
  logic [37:0] q0[$], q1[$], q2[$];
  int          last_unit = 2;
  logic        m_retire, m_we;
  logic [1:0]  m_unit;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .am_wb_valid(v[0]), .am_wb_ready(am_rdy), .am_wb_regdest(rd[0]),
    .am_wb_writereg(wr[0]), .am_wb_data(dt[0]),
    .mem_wb_valid(v[1]), .mem_wb_ready(mem_rdy), .mem_wb_regdest(rd[1]),
    .mem_wb_writereg(wr[1]), .mem_wb_data(dt[1]),
    .mul_wb_valid(v[2]), .mul_wb_ready(mul_rdy), .mul_wb_regdest(rd[2]),
    .mul_wb_writereg(wr[2]), .mul_wb_data(dt[2]),
    .wb_reg_addr(reg_addr), .wb_reg_data(reg_data), .wb_reg_we(reg_we),
    .wb_sb_addr(sb_addr), .wb_sb_unit(sb_unit), .wb_sb_enable(sb_en),
    .wb_retire(retire)
  );

  always #5 clock = ~clock;

  function automatic int qsize(int u);
    case (u)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model one clock edge from the queue contents seen before the edge.
  task automatic model_edge();
    int sz[3];
    bit acc[3];
    int g;
    logic [37:0] e;
    for (int u = 0; u < 3; u++) begin
      sz[u]  = qsize(u);
      acc[u] = v[u] && (sz[u] < DEPTH);
    end
    g = -1;
`ifdef WB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last_unit + k) % 3;
      if (g < 0 && sz[c] > 0) g = c;
    end
    if (g >= 0) last_unit = g;
`else
    if (sz[1] > 0) g = 1;
    else if (sz[2] > 0) g = 2;
    else if (sz[0] > 0) g = 0;
`endif
    if (g >= 0) begin
      if (g == 0) e = q0.pop_front();
      else if (g == 1) e = q1.pop_front();
      else e = q2.pop_front();
      m_retire = 1'b1;
      m_unit   = 2'(g);
      m_addr   = e[36:32];
      m_data   = e[31:0];
      m_we     = e[37] && (e[36:32] != 5'd0);
    end else begin
      m_retire = 1'b0; m_unit = 2'd0; m_addr = 5'd0; m_data = 32'd0; m_we = 1'b0;
    end
    if (acc[0]) q0.push_back({wr[0], rd[0], dt[0]});
    if (acc[1]) q1.push_back({wr[1], rd[1], dt[1]});
    if (acc[2]) q2.push_back({wr[2], rd[2], dt[2]});
  endtask

  // Reference model; reset discards everything asynchronously.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      q0.delete(); q1.delete(); q2.delete();
      last_unit = 2;
      m_retire = 1'b0; m_unit = 2'd0; m_addr = 5'd0; m_data = 32'd0; m_we = 1'b0;
    end else begin
      model_edge();
    end
  end

  // Compare all outputs against the model on every falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("retire", 32'(retire), 32'(m_retire));
      check("sb_unit", 32'(sb_unit), 32'(m_unit));
      check("reg_addr", 32'(reg_addr), 32'(m_addr));
      check("sb_addr", 32'(sb_addr), 32'(m_addr));
      check("reg_data", reg_data, m_data);
      check("reg_we", 32'(reg_we), 32'(m_we));
      check("sb_enable", 32'(sb_en), 32'(m_we));
      check("am_ready", 32'(am_rdy), 32'(q0.size() < DEPTH));
      check("mem_ready", 32'(mem_rdy), 32'(q1.size() < DEPTH));
      check("mul_ready", 32'(mul_rdy), 32'(q2.size() < DEPTH));
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic push_am(logic w, logic [4:0] r, logic [31:0] d);
    v = 3'b001; wr[0] = w; rd[0] = r; dt[0] = d;
    tick();
    v = 3'b000;
    tick();
  endtask

  initial begin
    logic [1:0] order[3];
    bit         dropped;
`ifdef WB_RR_EN
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2;
`else
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd0;
`endif
    do_reset();
    chk_en = 1'b1;
    #1;
    check("rst_am_ready", 32'(am_rdy), 32'd1);
    check("rst_mem_ready", 32'(mem_rdy), 32'd1);
    check("rst_mul_ready", 32'(mul_rdy), 32'd1);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_data", reg_data, 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);

    // Three units complete together.
    v = 3'b111; wr = 3'b111;
    rd[0] = 5'd1; rd[1] = 5'd2; rd[2] = 5'd3;
    dt[0] = 32'h0A0; dt[1] = 32'h0B0; dt[2] = 32'h0C0;
    tick();
    v = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("order_unit", 32'(sb_unit), 32'(order[i]));
      check("order_addr", 32'(reg_addr), 32'(order[i]) + 32'd1);
      check("order_retire", 32'(retire), 32'd1);
    end

    // Single AluMisc result.
    do_reset();
    push_am(1'b1, 5'd5, 32'h1234);
    check("single_retire", 32'(retire), 32'd1);
    check("single_we", 32'(reg_we), 32'd1);
    check("single_addr", 32'(reg_addr), 32'd5);
    check("single_data", reg_data, 32'h1234);
    check("single_unit", 32'(sb_unit), 32'd0);
    tick();
    check("idle_retire", 32'(retire), 32'd0);
    check("idle_we", 32'(reg_we), 32'd0);
    check("idle_data", reg_data, 32'd0);

    push_am(1'b0, 5'd7, 32'h5555);
    check("store_retire", 32'(retire), 32'd1);
    check("store_we", 32'(reg_we), 32'd0);
    check("store_sb_en", 32'(sb_en), 32'd0);

    push_am(1'b1, 5'd0, 32'h6666);
    check("r0_retire", 32'(retire), 32'd1);
    check("r0_we", 32'(reg_we), 32'd0);
    check("r0_sb_en", 32'(sb_en), 32'd0);

    // Reset with two entries buffered drops them silently.
    tick();
    v = 3'b011; wr = 3'b011; rd[0] = 5'd9; rd[1] = 5'd10;
    tick();
    v = 3'b000;
    #1 reset = 1'b0;
    #1;
    check("midrst_am_ready", 32'(am_rdy), 32'd1);
    check("midrst_mem_ready", 32'(mem_rdy), 32'd1);
    check("midrst_retire", 32'(retire), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_retire", 32'(retire), 32'd0);
    end

    // Contention: all units push back-to-back so FIFOs fill and wrap.
    dropped = 1'b0;
    for (int round = 0; round < 5; round++) begin
      for (int c = 0; c < 6; c++) begin
        v = 3'b111;
        for (int u = 0; u < 3; u++) begin
          rd[u] = 5'($urandom_range(1, 31));
          dt[u] = 32'((round << 8) | (u << 4) | c);
          wr[u] = 1'b1;
        end
        tick();
`ifdef WB_RR_EN
        if (!mem_rdy) dropped = 1'b1;
`else
        if (!am_rdy) dropped = 1'b1;
`endif
      end
      v = 3'b000;
      repeat (8) tick();
    end
    check("full_ready_dropped", 32'(dropped), 32'd1);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      v = 3'($urandom_range(0, 7));
      for (int u = 0; u < 3; u++) begin
        rd[u] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wr[u] = 1'($urandom_range(0, 1));
        dt[u] = $urandom;
      end
      tick();
    end
    v = 3'b000;
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
